// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encodings and shifter mode.
// The control unit imports this package so both sides agree on ALUOp values.
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int OP_W    = 4;
    localparam int SHAMT_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_AND   = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OR    = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR   = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SLL   = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SRL   = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SRA   = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLT   = 4'b1000;
    localparam logic [OP_W-1:0] ALU_PASSB = 4'b1001;

    // Direction and fill of the barrel shifter.
    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_kind_e;

    // Codes 1010..1111 are undefined.
    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        logic valid;
        if (op <= ALU_PASSB) begin
            valid = 1'b1;
        end else begin
            valid = 1'b0;
        end
        return valid;
    endfunction

    // Signed less-than producing the full-width SLT result.
    function automatic logic [DATA_W-1:0] slt_result(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        if ($signed(a) < $signed(b)) begin
            res = {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            res = {DATA_W{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter for SLL, SRL and SRA.
// Each stage shifts by a power of two when the matching amount bit is set.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_kind_e        kind_i,
    output logic [DATA_W-1:0]  result_o
);

    logic                  left_s;
    logic                  fill_s;
    logic [DATA_W-1:0]     stage_s [0:SHAMT_W];

    // Decode the shift direction and the bit shifted in on the right-shift path.
    always_comb begin
        left_s = 1'b0;
        fill_s = 1'b0;
        case (kind_i)
            SHIFT_SLL: begin
                left_s = 1'b1;
                fill_s = 1'b0;
            end
            SHIFT_SRL: begin
                left_s = 1'b0;
                fill_s = 1'b0;
            end
            SHIFT_SRA: begin
                left_s = 1'b0;
                fill_s = data_i[DATA_W-1];
            end
            default: begin
                left_s = 1'b0;
                fill_s = 1'b0;
            end
        endcase
    end

    assign stage_s[0] = data_i;

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int SH = 1 << s;
        logic [DATA_W-1:0] shifted_s;

        // One shifter stage: move by SH positions in the selected direction.
        always_comb begin
            if (left_s) begin
                shifted_s = {stage_s[s][DATA_W-1-SH:0], {SH{1'b0}}};
            end else begin
                shifted_s = {{SH{fill_s}}, stage_s[s][DATA_W-1:SH]};
            end
        end

        assign stage_s[s+1] = shamt_i[s] ? shifted_s : stage_s[s];
    end

    assign result_o = stage_s[SHAMT_W];

endmodule

// File: rtl/alu.sv
// 16-bit ALU with registered result, Zero, Negative and Invalid flags.
// Operands are sampled every rising edge; results appear one cycle later.
module alu
    import alu_pkg::*;
(
    input  logic              input_CLK,
    input  logic              input_Reset,
    input  logic [DATA_W-1:0] input_A,
    input  logic [DATA_W-1:0] input_B,
    input  logic [OP_W-1:0]   input_ALUOp,
    output logic [DATA_W-1:0] output_ALU,
    output logic              output_Zero,
    output logic              output_Negative,
    output logic              output_Invalid
);

    shift_kind_e       shift_kind_s;
    logic [DATA_W-1:0] shift_res_s;

    logic [DATA_W-1:0] alu_d;
    logic [DATA_W-1:0] alu_q;
    logic              zero_d;
    logic              zero_q;
    logic              neg_d;
    logic              neg_q;
    logic              inv_d;
    logic              inv_q;

    // Select shifter mode from the opcode; non-shift opcodes leave it idle on SRA.
    always_comb begin
        case (input_ALUOp)
            ALU_SLL: shift_kind_s = SHIFT_SLL;
            ALU_SRL: shift_kind_s = SHIFT_SRL;
            ALU_SRA: shift_kind_s = SHIFT_SRA;
            default: shift_kind_s = SHIFT_SRA;
        endcase
    end

    alu_shifter u_shifter (
        .data_i   (input_A),
        .shamt_i  (input_B[SHAMT_W-1:0]),
        .kind_i   (shift_kind_s),
        .result_o (shift_res_s)
    );

    // Operation mux; undefined opcodes produce a don't-care result and raise Invalid.
    always_comb begin
        alu_d = {DATA_W{1'b0}};
        inv_d = 1'b0;
        case (input_ALUOp)
            ALU_ADD:   alu_d = input_A + input_B;
            ALU_SUB:   alu_d = input_A - input_B;
            ALU_AND:   alu_d = input_A & input_B;
            ALU_OR:    alu_d = input_A | input_B;
            ALU_XOR:   alu_d = input_A ^ input_B;
            ALU_SLL:   alu_d = shift_res_s;
            ALU_SRL:   alu_d = shift_res_s;
            ALU_SRA:   alu_d = shift_res_s;
            ALU_SLT:   alu_d = slt_result(input_A, input_B);
            ALU_PASSB: alu_d = input_B;
            default: begin
                alu_d = {DATA_W{1'bx}};
                inv_d = 1'b1;
            end
        endcase
    end

    // Flags come from the same value that is registered; both are forced low when invalid.
    always_comb begin
        if (inv_d) begin
            zero_d = 1'b0;
            neg_d  = 1'b0;
        end else begin
            zero_d = (alu_d == {DATA_W{1'b0}});
            neg_d  = alu_d[DATA_W-1];
        end
    end

    // Output register: synchronous active-low reset has priority over the operands.
    always_ff @(posedge input_CLK) begin
        if (!input_Reset) begin
            alu_q  <= {DATA_W{1'b0}};
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            inv_q  <= inv_d;
        end
    end

    // Simulation-only notice when an undefined opcode is captured.
    always_ff @(posedge input_CLK) begin
        if (input_Reset && !op_is_valid(input_ALUOp)) begin
            $warning("alu: undefined ALUOp %b sampled", input_ALUOp);
        end
    end

    assign output_ALU      = alu_q;
    assign output_Zero     = zero_q;
    assign output_Negative = neg_q;
    assign output_Invalid  = inv_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops
// and compares them one cycle later. Random operations use an arithmetic model.
module tb_alu;

    typedef struct {
        logic [15:0] alu;
        logic        z;
        logic        n;
        logic        inv;
        bit          chk_alu;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] y;
    logic        zf;
    logic        nf;
    logic        invf;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu dut (
        .input_CLK       (clk),
        .input_Reset     (rst_n),
        .input_A         (a),
        .input_B         (b),
        .input_ALUOp     (op),
        .output_ALU      (y),
        .output_Zero     (zf),
        .output_Negative (nf),
        .output_Invalid  (invf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model computed with plain integer arithmetic.
    function automatic exp_t model(input logic r_n, input logic [3:0] o,
                                   input logic [15:0] av, input logic [15:0] bv,
                                   input string tag);
        exp_t   e;
        longint ua = longint'(av);
        longint ub = longint'(bv);
        longint sa = (ua >= 32768) ? ua - 65536 : ua;
        longint sbv = (ub >= 32768) ? ub - 65536 : ub;
        longint p = longint'(1) << (ub % 16);
        longint r = 0;
        e.inv = 1'b0;
        e.chk_alu = 1'b1;
        e.tag = tag;
        case (o)
            4'd0: r = (ua + ub) % 65536;
            4'd1: r = (ua - ub + 65536) % 65536;
            4'd2: r = longint'(av & bv);
            4'd3: r = longint'(av | bv);
            4'd4: r = longint'(av ^ bv);
            4'd5: r = (ua * p) % 65536;
            4'd6: r = ua / p;
            4'd7: r = (sa >= 0) ? sa / p : ((sa - (p - 1)) / p) + 65536;
            4'd8: r = (sa < sbv) ? 1 : 0;
            4'd9: r = ub;
            default: begin
                e.inv = 1'b1;
                e.chk_alu = 1'b0;
            end
        endcase
        e.alu = r[15:0];
        if (!r_n) begin
            e.alu = 16'h0000;
            e.inv = 1'b0;
            e.chk_alu = 1'b1;
        end
        e.z = !e.inv && r_n && (e.alu == 16'h0000);
        e.n = !e.inv && r_n && (r >= 32768);
        return e;
    endfunction

    task automatic drive_exp(input logic r_n, input logic [3:0] o, input logic [15:0] av,
                             input logic [15:0] bv, input exp_t e);
        @(negedge clk);
        rst_n = r_n;
        op = o;
        a = av;
        b = bv;
        sb.push_back(e);
    endtask

    task automatic directed(input logic r_n, input logic [3:0] o, input logic [15:0] av,
                            input logic [15:0] bv, input logic [15:0] ey, input logic ez,
                            input logic en, input logic ei, input bit ck, input string tag);
        exp_t e;
        e.alu = ey; e.z = ez; e.n = en; e.inv = ei; e.chk_alu = ck; e.tag = tag;
        drive_exp(r_n, o, av, bv, e);
    endtask

    // Monitor: one registered result per cycle, checked just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                bit   bad;
                e = sb.pop_front();
                bad = (zf !== e.z) || (nf !== e.n) || (invf !== e.inv) ||
                      (e.chk_alu && (y !== e.alu));
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got alu=%h z=%b n=%b inv=%b, expected alu=%h z=%b n=%b inv=%b (alu checked=%0d)",
                             e.tag, y, zf, nf, invf, e.alu, e.z, e.n, e.inv, e.chk_alu);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0;
        directed(1'b0, 4'd0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, "reset0");
        directed(1'b0, 4'd3, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, "reset1");
        directed(1'b1, 4'd0, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b0, 1'b0, 1'b1, "add");
        directed(1'b1, 4'd1, 16'h5678, 16'h1234, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, "sub");
        directed(1'b1, 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, "sub_wrap");
        directed(1'b1, 4'd2, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, "and");
        directed(1'b1, 4'd3, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, "or");
        directed(1'b1, 4'd4, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, "xor");
        directed(1'b1, 4'd5, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, "sll");
        directed(1'b1, 4'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, "srl");
        directed(1'b1, 4'd7, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b1, 1'b0, 1'b1, "sra");
        directed(1'b1, 4'd7, 16'h8000, 16'hFFF4, 16'hF800, 1'b0, 1'b1, 1'b0, 1'b1, "sra_hi_b");
        directed(1'b1, 4'd8, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, "slt");
        directed(1'b1, 4'd8, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, "slt_false");
        directed(1'b1, 4'd9, 16'h1111, 16'h8765, 16'h8765, 1'b0, 1'b1, 1'b0, 1'b1, "passb");
        directed(1'b1, 4'd15, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "invalid");
        directed(1'b1, 4'd0, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b0, 1'b0, 1'b1, "after_invalid");
        directed(1'b0, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, "reset_wins");
        directed(1'b1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, "add_wrap");

        for (int i = 0; i < 300; i++) begin
            logic        r_n;
            logic [3:0]  o;
            logic [15:0] av;
            logic [15:0] bv;
            r_n = ($urandom_range(0, 19) != 0);
            o   = 4'($urandom_range(0, 11));
            av  = 16'($urandom);
            bv  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) av = 16'h8000;
            drive_exp(r_n, o, av, bv, model(r_n, o, av, bv, $sformatf("rand%0d_op%0d", i, o)));
        end

        @(negedge clk);
        rst_n = 1'b1; op = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never observed, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

16-bit arithmetic logic unit for the multi-cycle processor datapath. It takes two operands and a 4-bit operation code. It registers the result together with Zero and Negative flags on each rising clock edge. The control unit and branch logic read these registered outputs in the cycle after the operands are presented.

## Interface

No parameters. Data width is fixed at 16 bits.

- input_CLK  input  1  system clock; all state changes on the rising edge
- input_Reset  input  1  reset; synchronous, active-low
- input_A  input  16  operand A
- input_B  input  16  operand B
- input_ALUOp  input  4  operation select
- output_ALU  output  16  registered result
- output_Zero  output  1  registered: result == 16'h0000
- output_Negative  output  1  registered: result bit 15
- output_Invalid  output  1  registered: the last sampled ALUOp was undefined

## Operation

Operation codes (two's-complement, modulo 2^16, no carry or overflow outputs):
- 0000 ADD: A + B
- 0001 SUB: A − B
- 0010 AND: A & B
- 0011 OR: A | B
- 0100 XOR: A ^ B
- 0101 SLL: A << B[3:0]
- 0110 SRL: A >> B[3:0], zero fill
- 0111 SRA: A >>> B[3:0], sign fill
- 1000 SLT: 16'h0001 if signed A < signed B, else 16'h0000
- 1001 PASSB: B
- 1010–1111: invalid

Flags:
- Zero = (result == 0).
- Negative = result[15].
- Both flags are computed from the same result that is registered into output_ALU.

Invalid opcode:
- output_ALU is loaded with all-X (16'hxxxx) in simulation; synthesis is free to drive any value.
- output_Zero = 0, output_Negative = 0, output_Invalid = 1.
- Simulation prints a warning message containing the opcode.

For shifts, B[15:4] is ignored.

## Timing

- Inputs are sampled on each rising edge of input_CLK. Outputs reflect those inputs after that edge: latency is 1 cycle, throughput is 1 operation per cycle.
- There is no handshake and no enable. The registers load every cycle.
- Reset: when input_Reset = 0 at a rising edge, output_ALU = 16'h0000, output_Zero = 0, output_Negative = 0 and output_Invalid = 0. Reset has priority over the operands.
- Reset deasserted: the first valid result appears one edge after the first non-reset edge.
- Inputs that change between edges have no effect until the next edge.
- Operand wrap-around:
  - ADD 16'hFFFF + 16'h0001 gives 16'h0000 with Zero = 1.
  - SUB 16'h0000 − 16'h0001 gives 16'hFFFF with Negative = 1.

## Structure

- Shared package holds:
  - the ALUOp localparams (ALU_ADD … ALU_PASSB);
  - the data width constant (16).
- The control unit imports the same package.
- One natural sub-module, alu_shifter: a combinational barrel shifter covering SLL, SRL and SRA.
- The top level contains:
  - the combinational operation mux;
  - flag generation;
  - the output register with synchronous reset.

## Test plan

Each operation check samples outputs one cycle after the inputs are applied.

- Reset low for 2 cycles with any operands -> all outputs 0. Release reset, then ADD A=1234 B=5678 -> 68AC, Z=0, N=0.
- SUB A=5678 B=1234 -> 4444, Z=0, N=0. SUB A=0000 B=0001 -> FFFF, N=1.
- AND A=AAAA B=5555 -> 0000, Z=1, N=0. OR with the same operands -> FFFF, Z=0, N=1. XOR with the same operands -> FFFF, Z=0, N=1.
- SLL A=8001 B=0001 -> 0002. SRL A=8000 B=000F -> 0001. SRA A=8000 B=0004 -> F800. SLT A=FFFF B=0001 -> 0001.
- ALUOp=1111 A=1234 B=5678 -> output_ALU all X, Invalid=1, Z=0, N=0, warning printed. Next cycle ADD -> Invalid=0.
- Assert reset in the same cycle as ADD A=FFFF B=0001 -> outputs 0 (reset wins). Next cycle, with reset released and the same ADD -> 0000, Z=1.
